// File: rtl/fnd_scan_ctrl.sv
`timescale 1ns/1ps
// fnd_scan_ctrl: 4-digit common-anode 7-segment scan controller.
// Per-frame snapshot, BCD split, segment encode, blinking centre dp.
module fnd_scan_ctrl #(
    parameter int F_CLK   = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mode,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_half_sec,
    output logic [3:0] o_fnd_com,
    output logic [7:0] o_fnd_data
);
    localparam int SCAN_DIV = F_CLK / SCAN_HZ;
    localparam int CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          upd_q, upd_d;
    logic          snap_mode_q, snap_mode_d;
    logic [6:0]    snap_lo_q, snap_lo_d;
    logic [6:0]    snap_hi_q, snap_hi_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    data_q, data_d;

    logic          strobe;
    logic [6:0]    sel_val;
    logic [7:0]    bcd;
    logic [3:0]    digit;
    logic [7:0]    seg_byte;
    logic          blank;
    logic          dp_lit;

    function automatic logic [6:0] sat99(input logic [6:0] x);
        return (x > 7'd99) ? 7'd99 : x;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] r;
        t = 4'd0;
        r = v;
        for (int k = 0; k < 9; k++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [7:0] seg(input logic [3:0] d);
        logic [7:0] s;
        unique case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Digit value, segment byte, blanking and dp for the current index
    always_comb begin
        sel_val  = idx_q[1] ? snap_hi_q : snap_lo_q;
        bcd      = to_bcd(sel_val);
        digit    = idx_q[0] ? bcd[7:4] : bcd[3:0];
        blank    = snap_mode_q && (idx_q == 2'd3) && (snap_hi_q < 7'd10);
        dp_lit   = (idx_q == 2'd2) && i_half_sec;
        seg_byte = blank ? 8'hFF : seg(digit);
        if (dp_lit) begin
            seg_byte[7] = 1'b0;
        end
    end

    // Divider, scan index, frame snapshot and output update
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        upd_d       = 1'b0;
        snap_mode_d = snap_mode_q;
        snap_lo_d   = snap_lo_q;
        snap_hi_d   = snap_hi_q;
        com_d       = com_q;
        data_d      = data_q;
        strobe      = (cnt_q == DIV_MAX);

        cnt_d = strobe ? '0 : cnt_q + 1'b1;
        if (strobe) begin
            idx_d = idx_q + 2'd1;
            upd_d = 1'b1;
            if (idx_q == 2'd3) begin
                snap_mode_d = i_mode;
                snap_lo_d   = sat99(i_mode ? {1'b0, i_min} : i_msec);
                snap_hi_d   = sat99(i_mode ? {2'b00, i_hour} : {1'b0, i_sec});
            end
        end
        if (upd_q) begin
            com_d  = ~(4'b0001 << idx_q);
            data_d = seg_byte;
        end
    end

    // State registers; everything dark in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            idx_q       <= 2'd3;
            upd_q       <= 1'b0;
            snap_mode_q <= 1'b0;
            snap_lo_q   <= 7'd0;
            snap_hi_q   <= 7'd0;
            com_q       <= 4'b1111;
            data_q      <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            upd_q       <= upd_d;
            snap_mode_q <= snap_mode_d;
            snap_lo_q   <= snap_lo_d;
            snap_hi_q   <= snap_hi_d;
            com_q       <= com_d;
            data_q      <= data_d;
        end
    end

    assign o_fnd_com  = com_q;
    assign o_fnd_data = data_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
`timescale 1ns/1ps
// tb_fnd_scan_ctrl: directed checks of scan order, digits, dp,
// snapshot timing, saturation, blanking and async reset.
module tb_fnd_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_mode = 1'b0;
    logic [6:0] i_msec = 7'd0;
    logic [5:0] i_sec = 6'd0;
    logic [5:0] i_min = 6'd0;
    logic [4:0] i_hour = 5'd0;
    logic       i_half_sec = 1'b0;
    logic [3:0] o_fnd_com;
    logic [7:0] o_fnd_data;

    int n_checks = 0;
    int n_fail = 0;

    fnd_scan_ctrl #(.F_CLK(1000), .SCAN_HZ(250)) dut (
        .clk(clk),
        .rst(rst),
        .i_mode(i_mode),
        .i_msec(i_msec),
        .i_sec(i_sec),
        .i_min(i_min),
        .i_hour(i_hour),
        .i_half_sec(i_half_sec),
        .o_fnd_com(o_fnd_com),
        .o_fnd_data(o_fnd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] ec,
                       input logic [7:0] ed);
        n_checks++;
        assert (o_fnd_com === ec) else begin
            n_fail++;
            $error("FAIL %s com got %b exp %b", tag, o_fnd_com, ec);
        end
        n_checks++;
        assert (o_fnd_data === ed) else begin
            n_fail++;
            $error("FAIL %s data got %h exp %h", tag, o_fnd_data, ed);
        end
    endtask

    task automatic next4();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Checks a whole frame starting at digit 0; returns just after digit 3
    task automatic frame(input string tag, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3);
        chk({tag, "_d0"}, 4'b1110, e0);
        next4();
        chk({tag, "_d1"}, 4'b1101, e1);
        next4();
        chk({tag, "_d2"}, 4'b1011, e2);
        next4();
        chk({tag, "_d3"}, 4'b0111, e3);
    endtask

    initial begin
        i_sec  = 6'd12;
        i_msec = 7'd34;
        #12;
        chk("reset", 4'b1111, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_first", 4'b1111, 8'hFF);
        @(posedge clk);
        #1;
        frame("t1", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        #2;
        chk("t1_hold", 4'b0111, 8'hF9);

        i_mode     = 1'b1;
        i_hour     = 5'd7;
        i_min      = 6'd5;
        i_half_sec = 1'b1;
        next4();
        frame("t2", 8'h92, 8'hC0, 8'h78, 8'hFF);

        i_mode     = 1'b0;
        i_half_sec = 1'b0;
        next4();
        chk("t3_d0", 4'b1110, 8'h99);
        next4();
        chk("t3_d1", 4'b1101, 8'hB0);
        i_sec  = 6'd59;
        i_mode = 1'b1;
        next4();
        chk("t3_d2", 4'b1011, 8'hA4);
        next4();
        chk("t3_d3", 4'b0111, 8'hF9);
        i_mode = 1'b0;
        next4();
        frame("t3n", 8'h99, 8'hB0, 8'h90, 8'h92);

        i_msec = 7'd127;
        next4();
        frame("t4", 8'h90, 8'h90, 8'h90, 8'h92);

        i_half_sec = 1'b1;
        next4();
        frame("t5a", 8'h90, 8'h90, 8'h10, 8'h92);
        i_half_sec = 1'b0;
        next4();
        frame("t5b", 8'h90, 8'h90, 8'h90, 8'h92);

        i_mode = 1'b1;
        i_hour = 5'd23;
        i_min  = 6'd59;
        next4();
        frame("hh23", 8'h90, 8'h92, 8'hB0, 8'hA4);

        i_mode = 1'b0;
        i_msec = 7'd34;
        i_sec  = 6'd12;
        next4();
        chk("t6_d0", 4'b1110, 8'h99);
        next4();
        chk("t6_d1", 4'b1101, 8'hB0);
        next4();
        chk("t6_d2", 4'b1011, 8'hA4);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async", 4'b1111, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_dark", 4'b1111, 8'hFF);
        @(posedge clk);
        #1;
        frame("t6r", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
